// File: rtl/pcore_interface_defs.sv
// Shared core definitions: fetch-align state encoding and compressed-length detection.
package pcore_interface_defs;

    typedef enum logic [1:0] {
        FALIGN_ALIGNED = 2'd0,
        FALIGN_SKIP    = 2'd1,
        FALIGN_RESIDUE = 2'd2
    } type_falign_state_e;

    // A half-word starts a 16-bit instruction unless its two low bits are 11.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Instruction fetch aligner: splits fetched words into 16/32-bit instructions.
// Compressed support is built only when PCORE_C_EXT_EN is defined; otherwise words pass straight through.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ALIGNED | next instruction starts at bit 0 of the incoming word
// SKIP    | redirect landed on an upper half; drop the lower half (bubble)
// RESIDUE | next instruction starts in the saved upper half r_res_q
module fetch_align
    import pcore_interface_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            word_valid_i,
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-3:0] word_addr_i,
    output logic            word_ready_o,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_is16_o,
    input  logic            inst_ready_i
);

    logic [XLEN-1:0] w_word_pc;
    assign w_word_pc = {word_addr_i, 2'b00};

`ifdef PCORE_C_EXT_EN

    type_falign_state_e r_state;
    type_falign_state_e w_state_nxt;
    logic [15:0]        r_res_q;
    logic [15:0]        w_res_nxt;
    logic [XLEN-1:0]    r_res_pc_q;
    logic [XLEN-1:0]    w_res_pc_nxt;
    logic [XLEN-1:0]    w_word_hi_pc;
    logic               w_in_xfer;
    logic               w_unused;

    assign w_word_hi_pc = {word_addr_i, 2'b10};
    assign w_in_xfer    = word_valid_i & inst_ready_i;
    assign w_unused     = ^{redirect_pc_i[XLEN-1:2], redirect_pc_i[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FALIGN_ALIGNED;
            r_res_q    <= '0;
            r_res_pc_q <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_res_q    <= w_res_nxt;
            r_res_pc_q <= w_res_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_res_nxt    = r_res_q;
        w_res_pc_nxt = r_res_pc_q;
        inst_valid_o = 1'b0;
        word_ready_o = 1'b0;
        inst_o       = word_i;
        inst_pc_o    = w_word_pc;
        inst_is16_o  = 1'b0;

        if (rst) begin
            w_state_nxt = FALIGN_ALIGNED;
        end else if (flush_i) begin
            // Redirect wins over everything; any presented word is drained and dropped.
            word_ready_o = 1'b1;
            w_state_nxt  = redirect_pc_i[1] ? FALIGN_SKIP : FALIGN_ALIGNED;
        end else begin
            case (r_state)
                FALIGN_ALIGNED: begin
                    inst_valid_o = word_valid_i;
                    if (is_compressed(word_i[15:0])) begin
                        inst_o       = {16'h0000, word_i[15:0]};
                        inst_is16_o  = 1'b1;
                        word_ready_o = w_in_xfer;
                        if (w_in_xfer) begin
                            w_res_nxt    = word_i[31:16];
                            w_res_pc_nxt = w_word_hi_pc;
                            w_state_nxt  = FALIGN_RESIDUE;
                        end
                    end else begin
                        word_ready_o = inst_ready_i;
                    end
                end
                FALIGN_SKIP: begin
                    word_ready_o = 1'b1;
                    if (word_valid_i) begin
                        w_res_nxt    = word_i[31:16];
                        w_res_pc_nxt = w_word_hi_pc;
                        w_state_nxt  = FALIGN_RESIDUE;
                    end
                end
                FALIGN_RESIDUE: begin
                    inst_pc_o = r_res_pc_q;
                    if (is_compressed(r_res_q)) begin
                        inst_valid_o = 1'b1;
                        inst_o       = {16'h0000, r_res_q};
                        inst_is16_o  = 1'b1;
                        if (inst_ready_i) begin
                            w_state_nxt = FALIGN_ALIGNED;
                        end
                    end else begin
                        // Straddling 32-bit instruction; upper half comes from the new word.
                        inst_valid_o = word_valid_i;
                        inst_o       = {word_i[15:0], r_res_q};
                        word_ready_o = inst_ready_i;
                        if (w_in_xfer) begin
                            w_res_nxt    = word_i[31:16];
                            w_res_pc_nxt = w_word_hi_pc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = FALIGN_ALIGNED;
                end
            endcase
        end
    end

`else

    logic w_unused;

    assign w_unused = ^{clk, redirect_pc_i};

    // No residue state: a flush only drains the word presented in its own cycle.
    always_comb begin
        inst_valid_o = 1'b0;
        word_ready_o = 1'b0;
        inst_o       = word_i;
        inst_pc_o    = w_word_pc;
        inst_is16_o  = 1'b0;
        if (!rst) begin
            if (flush_i) begin
                word_ready_o = 1'b1;
            end else begin
                inst_valid_o = word_valid_i;
                word_ready_o = inst_ready_i;
            end
        end
    end

`endif

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align; exercises the compressed aligner when PCORE_C_EXT_EN is defined.
module tb_fetch_align;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        word_valid_i;
    logic [31:0] word_i;
    logic [29:0] word_addr_i;
    logic        word_ready_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_is16_o;
    logic        inst_ready_i;

    int n_vec;
    int n_err;

    fetch_align #(.XLEN(32)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .word_valid_i  (word_valid_i),
        .word_i        (word_i),
        .word_addr_i   (word_addr_i),
        .word_ready_o  (word_ready_o),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_is16_o   (inst_is16_o),
        .inst_ready_i  (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic exp_inst(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic is16, input logic wready);
        chk({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd1);
        chk({tag, ".inst"},  inst_o, inst);
        chk({tag, ".pc"},    inst_pc_o, pc);
        chk({tag, ".is16"},  {31'd0, inst_is16_o}, {31'd0, is16});
        chk({tag, ".wrdy"},  {31'd0, word_ready_o}, {31'd0, wready});
    endtask

    task automatic exp_idle(input string tag, input logic wready);
        chk({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd0);
        chk({tag, ".wrdy"},  {31'd0, word_ready_o}, {31'd0, wready});
    endtask

    task automatic put_word(input logic v, input logic [31:0] w, input logic [31:0] byte_addr);
        word_valid_i = v;
        word_i       = w;
        word_addr_i  = byte_addr[31:2];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        flush_i       = 1'b0;
        redirect_pc_i = '0;
        word_valid_i  = 1'b0;
        word_i        = '0;
        word_addr_i   = '0;
        inst_ready_i  = 1'b1;

        put_word(1'b1, 32'h00A0_0513, 32'h0000_1000);
        exp_idle("rst", 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;

`ifdef PCORE_C_EXT_EN
        // full 32-bit word while aligned
        put_word(1'b1, 32'h00A0_0513, 32'h0000_1000);
        exp_inst("w32", 32'h00A0_0513, 32'h0000_1000, 1'b0, 1'b1);
        tick();

        // two compressed halves in one word
        put_word(1'b1, 32'h4585_4505, 32'h0000_2000);
        exp_inst("c16lo", 32'h0000_4505, 32'h0000_2000, 1'b1, 1'b1);
        tick();
        put_word(1'b0, 32'h0, 32'h0);
        exp_inst("c16hi", 32'h0000_4585, 32'h0000_2002, 1'b1, 1'b0);
        tick();

        // compressed, then straddling 32-bit, then compressed residue
        put_word(1'b1, 32'h0513_4505, 32'h0000_3000);
        exp_inst("st.c", 32'h0000_4505, 32'h0000_3000, 1'b1, 1'b1);
        tick();
        put_word(1'b1, 32'h0001_00A0, 32'h0000_3004);
        exp_inst("st.32", 32'h00A0_0513, 32'h0000_3002, 1'b0, 1'b1);
        tick();
        put_word(1'b0, 32'h0, 32'h0);
        exp_inst("st.res", 32'h0000_0001, 32'h0000_3006, 1'b1, 1'b0);
        tick();

        // flush to an upper half: drop presented word, bubble, then upper half
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_4002;
        put_word(1'b1, 32'h1234_5678, 32'h0000_5554);
        exp_idle("fl", 1'b1);
        tick();
        flush_i = 1'b0;
        put_word(1'b1, 32'h4585_0000, 32'h0000_4000);
        exp_idle("skip", 1'b1);
        tick();
        put_word(1'b0, 32'h0, 32'h0);
        exp_inst("skip.hi", 32'h0000_4585, 32'h0000_4002, 1'b1, 1'b0);
        tick();

        // back-pressure while straddling
        put_word(1'b1, 32'h0513_4505, 32'h0000_6000);
        tick();
        put_word(1'b1, 32'h0001_00A0, 32'h0000_6004);
        inst_ready_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_inst("hold", 32'h00A0_0513, 32'h0000_6002, 1'b0, 1'b0);
            tick();
        end
        inst_ready_i = 1'b1;
        #1;
        exp_inst("rel", 32'h00A0_0513, 32'h0000_6002, 1'b0, 1'b1);
        tick();
        put_word(1'b0, 32'h0, 32'h0);
        exp_inst("rel.next", 32'h0000_0001, 32'h0000_6006, 1'b1, 1'b0);
        tick();

        // flush mid-straddle discards residue
        put_word(1'b1, 32'h0513_4505, 32'h0000_7000);
        tick();
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_5000;
        put_word(1'b1, 32'h0001_00A0, 32'h0000_7004);
        exp_idle("msfl", 1'b1);
        tick();
        flush_i = 1'b0;
        put_word(1'b1, 32'h00A0_0513, 32'h0000_5000);
        exp_inst("msfl.next", 32'h00A0_0513, 32'h0000_5000, 1'b0, 1'b1);
        tick();

        // reset mid-straddle discards residue
        put_word(1'b1, 32'h0513_4505, 32'h0000_7000);
        tick();
        put_word(1'b1, 32'h0001_00A0, 32'h0000_7004);
        rst = 1'b1;
        #1;
        exp_idle("msrst", 1'b0);
        tick();
        rst = 1'b0;
        put_word(1'b1, 32'h00A0_0513, 32'h0000_5000);
        exp_inst("msrst.next", 32'h00A0_0513, 32'h0000_5000, 1'b0, 1'b1);
        tick();

        // straddle across the top of the address space
        flush_i       = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        put_word(1'b0, 32'h0, 32'h0);
        tick();
        flush_i = 1'b0;
        put_word(1'b1, 32'h0513_0000, 32'hFFFF_FFFC);
        exp_idle("wrap.skip", 1'b1);
        tick();
        put_word(1'b1, 32'h0001_00A0, 32'h0000_0000);
        exp_inst("wrap", 32'h00A0_0513, 32'hFFFF_FFFE, 1'b0, 1'b1);
        tick();
`else
        put_word(1'b1, 32'h00A0_0513, 32'h0000_1000);
        exp_inst("w32", 32'h00A0_0513, 32'h0000_1000, 1'b0, 1'b1);
        tick();

        // compressed-looking words pass through whole
        put_word(1'b1, 32'h4585_4505, 32'h0000_2000);
        exp_inst("pass", 32'h4585_4505, 32'h0000_2000, 1'b0, 1'b1);
        inst_ready_i = 1'b0;
        #1;
        exp_inst("bp", 32'h4585_4505, 32'h0000_2000, 1'b0, 1'b0);
        inst_ready_i = 1'b1;
        tick();

        put_word(1'b0, 32'h0513_4505, 32'h0000_3000);
        exp_idle("novalid", 1'b1);
        tick();

        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_4002;
        put_word(1'b1, 32'h1234_5678, 32'h0000_5554);
        exp_idle("fl", 1'b1);
        tick();
        flush_i = 1'b0;
        put_word(1'b1, 32'h4585_0000, 32'h0000_4000);
        exp_inst("fl.next", 32'h4585_0000, 32'h0000_4000, 1'b0, 1'b1);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
